// File: rtl/alu_execute_stage.sv
// Two-stage execute stage: operand latch plus ALU drive, then a registered result
// toward writeback. Arithmetic shift and the two compares are resolved here, not in the ALU.
module alu_execute_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [XLEN-1:0]       in_rs1_value,
    input  logic [XLEN-1:0]       in_rs2_value,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [3:0]            alu_operation,
    input  logic [XLEN-1:0]       alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_value,
    output logic                  out_write_enable,
    output logic [31:0]           retired_count
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_LT   = 4'd9;
    localparam logic [3:0] OP_LTU  = 4'd10;

    logic                  s1_valid;
    logic [3:0]            s1_op;
    logic [XLEN-1:0]       s1_a;
    logic [XLEN-1:0]       s1_b;
    logic [REG_ADDR_W-1:0] s1_rd;
    logic                  s2_valid;
    logic [3:0]            s2_op;

    logic            s2_free;
    logic            s1_advance;
    logic            in_fire;
    logic            out_fire;
    logic [XLEN-1:0] b_sel;
    logic [XLEN-1:0] b_latched;
    logic [XLEN-1:0] result;

    assign s2_free    = !s2_valid | out_ready;
    assign s1_advance = s1_valid & s2_free;
    assign in_ready   = rst_n & !flush & (!s1_valid | s2_free);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = s2_valid & out_ready;

    // Shift amounts are trimmed to five bits once, at latch time.
    always_comb begin
        b_sel     = in_use_imm ? in_imm : in_rs2_value;
        b_latched = b_sel;
        if (in_op == OP_SLL || in_op == OP_SRL || in_op == OP_SRA)
            b_latched = {{(XLEN-5){1'b0}}, b_sel[4:0]};
    end

    assign alu_a = s1_a;
    assign alu_b = s1_b;

    always_comb begin
        alu_operation = OP_NONE;
        if (s1_valid && !(s1_op inside {OP_SRA, OP_LT, OP_LTU}))
            alu_operation = s1_op;
    end

    always_comb begin
        result = alu_result;
        case (s1_op)
            OP_NONE: result = '0;
            OP_SRA:  result = $signed(s1_a) >>> s1_b[4:0];
            OP_LT:   result = {{(XLEN-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
            OP_LTU:  result = {{(XLEN-1){1'b0}}, s1_a < s1_b};
            default: result = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NONE;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rd    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_rs1_value;
            s1_b     <= b_latched;
            s1_rd    <= in_rd;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_op     <= OP_NONE;
            out_value <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_advance) begin
            s2_valid  <= 1'b1;
            s2_op     <= s1_op;
            out_value <= result;
            out_rd    <= s1_rd;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Handshakes in a flush cycle still retire; the counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_count <= '0;
        else if (out_fire)
            retired_count <= retired_count + 32'd1;
    end

    assign out_valid        = s2_valid;
    assign out_write_enable = s2_valid & (out_rd != '0) & (s2_op != OP_NONE);

endmodule
